ttt_move_ctrl: RTL and testbench

Turn and move controller for the tic-tac-toe board: accepts player moves over a valid/ready handshake, rejects illegal ones, and commits legal moves by pulsing the `set` input of one of the nine board cells with the current player's symbol. It sits directly upstream of the nine-cell board array and reads the cells' `valid`/`symbol` outputs back to decide legality, win and draw. It also owns board clearing, driving the cells' synchronous `reset` at power-up and on `new_game`.

---
 rtl/ttt_pkg.sv | 25 ++
 rtl/ttt_line_check.sv | 36 +++
 rtl/ttt_move_ctrl.sv | 96 +++++++++
 tb/tb_ttt_move_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared constants for the tic-tac-toe controller: FSM encoding, status codes
// and the table of the eight winning lines.
package ttt_pkg;

  localparam int unsigned N_CELLS = 9;

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] STATUS_PLAYING = 2'd0;
  localparam logic [1:0] STATUS_WIN0    = 2'd1;
  localparam logic [1:0] STATUS_WIN1    = 2'd2;
  localparam logic [1:0] STATUS_DRAW    = 2'd3;

  // Each entry packs three row-major cell indices, one per nibble.
  localparam logic [11:0] LINE_TABLE [8] = '{
    12'h012, 12'h345, 12'h678,
    12'h036, 12'h147, 12'h258,
    12'h048, 12'h246
  };

endpackage

// File: rtl/ttt_line_check.sv
// Combinational board evaluator: reports a completed line, its owner, and
// whether every cell is occupied.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [N_CELLS-1:0] valid,
  input  logic [N_CELLS-1:0] symbol,
  output logic               win,
  output logic               winner,
  output logic               full
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;

  always_comb begin
    win    = 1'b0;
    winner = 1'b0;
    a      = '0;
    b      = '0;
    c      = '0;
    for (int unsigned l = 0; l < 8; l++) begin
      a = LINE_TABLE[l][11:8];
      b = LINE_TABLE[l][7:4];
      c = LINE_TABLE[l][3:0];
      if (!win && valid[a] && valid[b] && valid[c] &&
          (symbol[a] == symbol[b]) && (symbol[b] == symbol[c])) begin
        win    = 1'b1;
        winner = symbol[a];
      end
    end
    full = &valid;
  end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Turn and move controller: accepts moves by handshake, strobes the target
// cell, then judges win/draw from the cells' outputs one cycle later.
module ttt_move_ctrl
  import ttt_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic [3:0]         move_idx,
  output logic               move_ready,
  output logic               move_err,
  output logic [N_CELLS-1:0] cell_set,
  output logic               cell_set_symbol,
  output logic               cell_reset,
  input  logic [N_CELLS-1:0] cell_valid,
  input  logic [N_CELLS-1:0] cell_symbol,
  output logic               turn,
  output logic [1:0]         status
);

  logic [2:0] state;
  logic [3:0] idx_q;
  logic       occupied;
  logic       legal;
  logic       handshake;
  logic       win;
  logic       winner;
  logic       full;

  ttt_line_check u_line_check (
    .valid  (cell_valid),
    .symbol (cell_symbol),
    .win    (win),
    .winner (winner),
    .full   (full)
  );

  // Out-of-range indices are treated as occupied so they never reach the array.
  always_comb begin
    occupied = 1'b1;
    if (move_idx <= 4'd8) occupied = cell_valid[move_idx];
    legal     = !occupied;
    handshake = move_valid && move_ready;
  end

  always_comb begin
    move_ready      = (state == S_WAIT);
    cell_reset      = (state == S_CLEAR);
    cell_set        = (state == S_COMMIT) ? (N_CELLS'(1) << idx_q) : '0;
    cell_set_symbol = (state == S_COMMIT) && turn;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_CLEAR;
      idx_q    <= '0;
      turn     <= 1'b0;
      status   <= STATUS_PLAYING;
      move_err <= 1'b0;
    end else begin
      move_err <= handshake && !legal && !new_game;
      case (state)
        S_CLEAR: begin
          turn   <= 1'b0;
          status <= STATUS_PLAYING;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (handshake && legal) begin
            idx_q <= move_idx;
            state <= S_COMMIT;
          end
        end
        S_COMMIT: state <= S_CHECK;
        S_CHECK: begin
          if (win) begin
            status <= winner ? STATUS_WIN1 : STATUS_WIN0;
            state  <= S_DONE;
          end else if (full) begin
            status <= STATUS_DRAW;
            state  <= S_DONE;
          end else begin
            turn  <= ~turn;
            state <= S_WAIT;
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_CLEAR;
      endcase
      // new_game overrides only the next state; CLEAR itself reloads turn/status.
      if (new_game) state <= S_CLEAR;
    end
  end

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl with a behavioural model of the nine-cell array.
module tb_ttt_move_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_idx;
  logic       move_ready;
  logic       move_err;
  logic [8:0] cell_set;
  logic       cell_set_symbol;
  logic       cell_reset;
  logic       turn;
  logic [1:0] status;

  logic [8:0] cv = 9'h1A5;
  logic [8:0] cs = 9'h0F3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ttt_move_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .new_game        (new_game),
    .move_valid      (move_valid),
    .move_idx        (move_idx),
    .move_ready      (move_ready),
    .move_err        (move_err),
    .cell_set        (cell_set),
    .cell_set_symbol (cell_set_symbol),
    .cell_reset      (cell_reset),
    .cell_valid      (cv),
    .cell_symbol     (cs),
    .turn            (turn),
    .status          (status)
  );

  always @(posedge clk) begin
    if (cell_reset) cv <= '0;
    else
      for (int i = 0; i < 9; i++)
        if (cell_set[i]) begin
          cv[i] <= 1'b1;
          cs[i] <= cell_set_symbol;
        end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && move_ready !== 1'b1; i++) @(negedge clk);
    if (move_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got=%0b exp=1", move_ready);
    end
  endtask

  task automatic start_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("ng_clear", cell_reset, 1);
    @(negedge clk);
    chk("ng_ready", move_ready, 1);
    chk("ng_cells", cv, 0);
    chk("ng_turn", turn, 0);
    chk("ng_status", status, 0);
  endtask

  // Returns at the negedge of the cycle after the handshake edge.
  task automatic handshake(input logic [3:0] idx);
    wait_ready();
    move_valid = 1'b1;
    move_idx   = idx;
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic apply_move(input logic [3:0] idx, input logic err, input logic sym,
                            input logic exp_turn, input logic [1:0] exp_st);
    logic [8:0] one;
    one = 9'd1 << idx;
    handshake(idx);
    chk("move_err", move_err, err);
    if (err) begin
      chk("err_no_set", cell_set, 0);
      chk("err_ready", move_ready, 1);
    end else begin
      chk("cell_set", cell_set, one);
      chk("set_sym", cell_set_symbol, sym);
      @(negedge clk);
      chk("check_no_set", cell_set, 0);
      @(negedge clk);
    end
    chk("turn", turn, exp_turn);
    chk("status", status, exp_st);
    chk("ready_after", move_ready, exp_st == 2'd0);
  endtask

  typedef struct {
    logic       ng;
    logic [3:0] idx;
    logic       err;
    logic       sym;
    logic       turn;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic ng, input logic [3:0] idx, input logic err,
                              input logic sym, input logic t, input logic [1:0] st);
    vec_t v;
    v.ng = ng; v.idx = idx; v.err = err; v.sym = sym; v.turn = t; v.st = st;
    tbl.push_back(v);
  endfunction

  // Reference model: board of 0 empty / 1 player0 / 2 player1.
  int         b[9];
  logic       m_turn;
  logic [1:0] m_st;

  function automatic logic [1:0] judge();
    int w;
    w = 0;
    for (int r = 0; r < 3; r++)
      if (b[3*r] != 0 && b[3*r] == b[3*r+1] && b[3*r] == b[3*r+2]) w = b[3*r];
    for (int c = 0; c < 3; c++)
      if (b[c] != 0 && b[c] == b[c+3] && b[c] == b[c+6]) w = b[c];
    if (b[4] != 0 && ((b[0] == b[4] && b[8] == b[4]) || (b[2] == b[4] && b[6] == b[4])))
      w = b[4];
    if (w != 0) return 2'(w);
    for (int i = 0; i < 9; i++) if (b[i] == 0) return 2'd0;
    return 2'd3;
  endfunction

  initial begin
    reset_n    = 1'b0;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_idx   = '0;

    #23;
    chk("rst_cell_reset", cell_reset, 1);
    chk("rst_ready", move_ready, 0);
    chk("rst_err", move_err, 0);
    chk("rst_set", cell_set, 0);
    chk("rst_sym", cell_set_symbol, 0);
    chk("rst_turn", turn, 0);
    chk("rst_status", status, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rel_clear", cell_reset, 1);
    @(negedge clk);
    chk("rel_clear_done", cell_reset, 0);
    chk("rel_ready", move_ready, 1);
    chk("rel_cells", cv, 0);

    // Game A: occupied and out-of-range moves.
    add(1, 4, 0, 0, 1, 0); add(0, 4, 1, 0, 1, 0); add(0, 12, 1, 0, 1, 0); add(0, 0, 0, 1, 0, 0);
    // Draw.
    add(1, 0, 0, 0, 1, 0); add(0, 1, 0, 1, 0, 0); add(0, 2, 0, 0, 1, 0); add(0, 4, 0, 1, 0, 0);
    add(0, 3, 0, 0, 1, 0); add(0, 5, 0, 1, 0, 0); add(0, 7, 0, 0, 1, 0); add(0, 6, 0, 1, 0, 0);
    add(0, 8, 0, 0, 0, 3);
    // Ninth move fills the board and completes column 0: win beats draw.
    add(1, 0, 0, 0, 1, 0); add(0, 1, 0, 1, 0, 0); add(0, 2, 0, 0, 1, 0); add(0, 4, 0, 1, 0, 0);
    add(0, 3, 0, 0, 1, 0); add(0, 5, 0, 1, 0, 0); add(0, 7, 0, 0, 1, 0); add(0, 8, 0, 1, 0, 0);
    add(0, 6, 0, 0, 0, 1);
    // Player 1 wins row 1.
    add(1, 0, 0, 0, 1, 0); add(0, 4, 0, 1, 0, 0); add(0, 1, 0, 0, 1, 0); add(0, 3, 0, 1, 0, 0);
    add(0, 8, 0, 0, 1, 0); add(0, 5, 0, 1, 1, 2);
    // Player 0 wins row 0; leaves the controller in DONE.
    add(1, 0, 0, 0, 1, 0); add(0, 3, 0, 1, 0, 0); add(0, 1, 0, 0, 1, 0); add(0, 4, 0, 1, 0, 0);
    add(0, 2, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      if (tbl[i].ng) start_game();
      apply_move(tbl[i].idx, tbl[i].err, tbl[i].sym, tbl[i].turn, tbl[i].st);
      if (i == 1) chk("cell4_kept", {cv[4], cs[4]}, 2'b10);
    end

    chk("done_ready", move_ready, 0);
    move_valid = 1'b1;
    move_idx   = 4'd5;
    repeat (3) begin
      @(negedge clk);
      chk("done_no_set", cell_set, 0);
      chk("done_no_err", move_err, 0);
      chk("done_status", status, 1);
    end
    move_valid = 1'b0;

    // new_game in the same cycle as a handshake drops the move.
    start_game();
    apply_move(0, 0, 0, 1, 0);
    wait_ready();
    move_valid = 1'b1;
    move_idx   = 4'd5;
    new_game   = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    new_game   = 1'b0;
    chk("ngh_err", move_err, 0);
    chk("ngh_set", cell_set, 0);
    chk("ngh_clear", cell_reset, 1);
    @(negedge clk);
    chk("ngh_ready", move_ready, 1);
    chk("ngh_turn", turn, 0);
    chk("ngh_cells", cv, 0);
    chk("ngh_err2", move_err, 0);

    // new_game during COMMIT, held for two cycles.
    apply_move(0, 0, 0, 1, 0);
    handshake(4'd2);
    chk("ngc_set", cell_set, 9'h004);
    new_game = 1'b1;
    @(negedge clk);
    chk("ngc_clear1", cell_reset, 1);
    @(negedge clk);
    chk("ngc_clear2", cell_reset, 1);
    chk("ngc_not_ready", move_ready, 0);
    new_game = 1'b0;
    @(negedge clk);
    chk("ngc_ready", move_ready, 1);
    chk("ngc_cells", cv, 0);
    chk("ngc_turn", turn, 0);
    chk("ngc_status", status, 0);
    chk("ngc_err", move_err, 0);

    // Asynchronous abort while COMMIT is strobing.
    apply_move(4, 0, 0, 1, 0);
    handshake(4'd1);
    chk("abort_set_pre", cell_set, 9'h002);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_set", cell_set, 0);
    chk("abort_clear", cell_reset, 1);
    chk("abort_turn", turn, 0);
    chk("abort_ready", move_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_ready2", move_ready, 1);
    chk("abort_cells", cv, 0);

    // Random games against the model.
    for (int g = 0; g < 8; g++) begin
      logic [3:0] idx;
      logic       err;
      logic       sym;
      start_game();
      foreach (b[i]) b[i] = 0;
      m_turn = 1'b0;
      m_st   = 2'd0;
      for (int s = 0; s < 40 && m_st == 2'd0; s++) begin
        if ($urandom_range(0, 3) == 0) idx = 4'($urandom_range(0, 15));
        else idx = 4'($urandom_range(0, 8));
        err = (idx > 4'd8) || (b[idx] != 0);
        sym = m_turn;
        if (!err) begin
          b[idx] = m_turn ? 2 : 1;
          m_st = judge();
          if (m_st == 2'd0) m_turn = ~m_turn;
        end
        apply_move(idx, err, sym, m_turn, m_st);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
